huffman_encoder: RTL and testbench

- Downstream neighbour of the pruning stage. Consumes one pruned weight vector of col signed bw-bit elements per transaction.
- Encodes each element with a fixed prefix code. Zero gets a 1-bit code; a nonzero value gets a flag bit plus its raw value.
- Packs the code bits LSB-first into out_bw-bit words for the weight SRAM/FIFO write port, with valid/ready handshakes on both sides.
- An explicit flush emits the final partial word.

---
 rtl/huff_pkg.sv | 49 ++++
 rtl/huff_bit_packer.sv | 103 ++++++++++
 rtl/huffman_encoder.sv | 159 +++++++++++++++
 tb/tb_huffman_encoder.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/huff_pkg.sv
`default_nettype none
// ============================================================================
// Module  : huff_pkg
// Brief   : Shared definitions for the Huffman weight encoder: FSM state
//           encoding, prefix-code constants and the code lookup function.
// Revision: 1.0 - initial release
// ============================================================================
package huff_pkg;

   // Widest code word and length field the lookup function can return
   localparam int CODE_W = 32;
   localparam int LEN_W  = 16;

   // Encoder FSM states
   typedef logic [1:0] state_t;
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ENCODE = 2'd1;
   localparam logic [1:0] FLUSH  = 2'd2;

   // Zero is the common case after pruning, so it gets the 1-bit code
   localparam logic ZERO_CODE = 1'b0;
   localparam int   ZERO_LEN  = 1;

   typedef struct packed {
      logic [LEN_W-1:0]  len;
      logic [CODE_W-1:0] code;
   } huff_code_t;

   // Nonzero code length: one flag bit plus the raw element
   function automatic int nz_len(input int bw);
      return bw + 1;
   endfunction

   // value holds the raw element bits zero-extended; bw is the element width.
   // Nonzero codes put the flag bit at the LSB, then the value LSB-first.
   function automatic huff_code_t huff_code(input logic [CODE_W-1:0] value, input int bw);
      huff_code_t c;
      if (value == '0) begin
         c.len  = LEN_W'(ZERO_LEN);
         c.code = {{(CODE_W-1){1'b0}}, ZERO_CODE};
      end else begin
         c.len  = LEN_W'(nz_len(bw));
         c.code = {value[CODE_W-2:0], 1'b1};
      end
      return c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/huff_bit_packer.sv
`default_nettype none
// ============================================================================
// Module  : huff_bit_packer
// Brief   : Bit buffer of 2*OUT_BW bits that accepts variable-length codes
//           when there is room, drains full words into a one-entry output
//           register and pads the final partial word on request.
// Revision: 1.0 - initial release
// ============================================================================
module huff_bit_packer #(
   parameter int OUT_BW  = 32,
   parameter int CODE_BW = 5,
   parameter int FILL_W  = $clog2(2*OUT_BW) + 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               app_valid,
   input  logic [CODE_BW-1:0] app_code,
   input  logic [FILL_W-1:0]  app_len,
   output logic               app_ready,
   input  logic               pad_req,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [OUT_BW-1:0]  out_data,
   output logic               out_last,
   output logic [FILL_W-1:0]  fill,
   output logic               word_pop
);

   localparam int                BUF_W     = 2 * OUT_BW;
   localparam logic [FILL_W:0]   BUF_LIM   = (FILL_W+1)'(BUF_W);
   localparam logic [FILL_W-1:0] WORD_FILL = FILL_W'(OUT_BW);

   logic [BUF_W-1:0]  bit_buf;
   logic [BUF_W-1:0]  merged;
   logic [BUF_W-1:0]  buf_next;
   logic [FILL_W-1:0] fill_sum;
   logic [FILL_W-1:0] fill_next;
   logic              pop;
   logic              out_free;
   logic              app_fire;
   logic              load_word;
   logic              load_pad;

   assign pop       = out_valid && out_ready;
   assign out_free  = !out_valid || pop;
   assign app_ready = ({1'b0, fill} + {1'b0, app_len}) <= BUF_LIM;
   assign app_fire  = app_valid && app_ready;
   assign load_word = (fill >= WORD_FILL) && out_free;
   // Bits above fill are always zero, so the low word is already padded
   assign load_pad  = pad_req && !app_valid && out_free && (fill != '0) && (fill < WORD_FILL);
   assign word_pop  = pop;

   // Append the incoming code above the current fill, then drop a loaded word
   always_comb begin
      merged   = bit_buf;
      fill_sum = fill;
      if (app_fire) begin
         merged   = bit_buf | (BUF_W'(app_code) << fill);
         fill_sum = fill + app_len;
      end
      buf_next  = merged;
      fill_next = fill_sum;
      if (load_word) begin
         buf_next  = merged >> OUT_BW;
         fill_next = fill_sum - WORD_FILL;
      end else if (load_pad) begin
         buf_next  = '0;
         fill_next = '0;
      end
   end

   // Buffer and fill level
   always_ff @(posedge clk) begin
      if (reset) begin
         bit_buf <= '0;
         fill    <= '0;
      end else begin
         bit_buf <= buf_next;
         fill    <= fill_next;
      end
   end

   // Output word register; contents hold until the consumer pops
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
      end else if (load_word) begin
         out_valid <= 1'b1;
         out_data  <= bit_buf[OUT_BW-1:0];
         out_last  <= 1'b0;
      end else if (load_pad) begin
         out_valid <= 1'b1;
         out_data  <= bit_buf[OUT_BW-1:0];
         out_last  <= 1'b1;
      end else if (pop) begin
         out_valid <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: rtl/huffman_encoder.sv
`default_nettype none
// ============================================================================
// Module  : huffman_encoder
// Brief   : Encodes pruned weight vectors with a fixed prefix code (zero ->
//           1 bit, nonzero -> flag + raw value) and packs the bits LSB-first
//           into OUT_BW-bit words, one element per cycle.
//           Optional build macro HUFF_STATS_EN adds zero_cnt / word_cnt.
//           OUT_BW must be at least 2*(BW+1).
// Revision: 1.0 - initial release
// ============================================================================
module huffman_encoder
   import huff_pkg::*;
#(
   parameter int COL    = 8,
   parameter int BW     = 4,
   parameter int OUT_BW = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [BW*COL-1:0] in_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OUT_BW-1:0] out_data,
   output logic              out_last,
   output logic              flush_done
`ifdef HUFF_STATS_EN
   ,
   output logic [31:0]       zero_cnt,
   output logic [31:0]       word_cnt
`endif
);

   localparam int               IDX_W    = (COL > 1) ? $clog2(COL) : 1;
   localparam int               FILL_W   = $clog2(2*OUT_BW) + 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(COL-1);

   state_t            state;
   logic [IDX_W-1:0]  idx;
   logic [BW*COL-1:0] vec;
   logic              flush_pend;
   logic [BW-1:0]     elem;
   huff_code_t        code;
   logic              app_valid;
   logic              app_ready;
   logic              app_fire;
   logic              pad_req;
   logic              word_pop;
   logic              accept;
   logic              flush_any;
   logic              last_elem;
   logic [FILL_W-1:0] fill;
   logic              unused_code_bits;

   assign in_ready   = (state == IDLE);
   assign accept     = in_valid && in_ready;
   // A flush arriving this cycle counts as pending for state decisions
   assign flush_any  = flush_pend || flush;
   assign elem       = vec[int'(idx)*BW +: BW];
   assign code       = huff_code(CODE_W'(elem), BW);
   assign app_valid  = (state == ENCODE);
   assign app_fire   = app_valid && app_ready;
   assign last_elem  = (idx == LAST_IDX);
   assign pad_req    = (state == FLUSH);
   // Flush completes once every word, including the padded one, has left
   assign flush_done = (state == FLUSH) && (fill == '0) && !out_valid;
   assign unused_code_bits = ^{code.code[CODE_W-1:BW+1], code.len[LEN_W-1:FILL_W]};

   huff_bit_packer #(
      .OUT_BW  (OUT_BW),
      .CODE_BW (BW + 1),
      .FILL_W  (FILL_W)
   ) u_packer (
      .clk       (clk),
      .reset     (reset),
      .app_valid (app_valid),
      .app_code  (code.code[BW:0]),
      .app_len   (code.len[FILL_W-1:0]),
      .app_ready (app_ready),
      .pad_req   (pad_req),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .fill      (fill),
      .word_pop  (word_pop)
   );

   // Remember a flush request until the flush sequence completes
   always_ff @(posedge clk) begin
      if (reset) begin
         flush_pend <= 1'b0;
      end else if (flush) begin
         flush_pend <= 1'b1;
      end else if (flush_done) begin
         flush_pend <= 1'b0;
      end
   end

   // Control FSM: capture a vector, walk its elements, then flush or idle
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         idx   <= '0;
         vec   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  vec   <= in_data;
                  idx   <= '0;
                  state <= ENCODE;
               end else if (flush_any) begin
                  state <= FLUSH;
               end
            end
            ENCODE: begin
               if (app_fire) begin
                  if (last_elem) begin
                     state <= flush_any ? FLUSH : IDLE;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            FLUSH: begin
               if (flush_done) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef HUFF_STATS_EN
   // Saturating counts of zero elements encoded and words popped
   always_ff @(posedge clk) begin
      if (reset) begin
         zero_cnt <= '0;
         word_cnt <= '0;
      end else begin
         if (app_fire && (elem == '0) && (zero_cnt != '1)) begin
            zero_cnt <= zero_cnt + 32'd1;
         end
         if (word_pop && (word_cnt != '1)) begin
            word_cnt <= word_cnt + 32'd1;
         end
      end
   end
`else
   logic unused_word_pop;
   assign unused_word_pop = word_pop;
`endif

endmodule
`default_nettype wire

// File: tb/tb_huffman_encoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_huffman_encoder
// Brief   : Self-checking bench for huffman_encoder. A bit-queue model turns
//           each accepted vector into code bits and expected output words;
//           a compare process checks every popped word and output hold.
// Revision: 1.0 - initial release
// ============================================================================
module tb_huffman_encoder;

   localparam int COL    = 8;
   localparam int BW     = 4;
   localparam int OUT_BW = 32;

   typedef struct packed {
      logic              last;
      logic [OUT_BW-1:0] data;
   } word_t;

   logic              clk = 1'b0;
   logic              reset;
   logic              in_valid;
   logic              in_ready;
   logic [BW*COL-1:0] in_data;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic [OUT_BW-1:0] out_data;
   logic              out_last;
   logic              flush_done;
`ifdef HUFF_STATS_EN
   logic [31:0]       zero_cnt;
   logic [31:0]       word_cnt;
`endif

   int    vectors     = 0;
   int    miscompares = 0;
   int    fd_count    = 0;
   word_t exp_q[$];
   word_t got_q[$];
   bit    bits_q[$];
   logic              prev_stall = 1'b0;
   logic [OUT_BW-1:0] prev_data  = '0;
   logic              prev_last  = 1'b0;

   always #5 clk = ~clk;

   huffman_encoder #(.COL(COL), .BW(BW), .OUT_BW(OUT_BW)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_last   (out_last),
      .flush_done (flush_done)
`ifdef HUFF_STATS_EN
      ,
      .zero_cnt   (zero_cnt),
      .word_cnt   (word_cnt)
`endif
   );

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic fail_now(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s: bound expired", name);
   endtask

   // Model: code bits of every element go into one bit stream
   task automatic model_push(input logic [BW*COL-1:0] v);
      word_t w;
      for (int i = 0; i < COL; i++) begin
         logic [BW-1:0] e;
         e = v[i*BW +: BW];
         if (e == 0) begin
            bits_q.push_back(1'b0);
         end else begin
            bits_q.push_back(1'b1);
            for (int b = 0; b < BW; b++) bits_q.push_back(e[b]);
         end
      end
      while (bits_q.size() >= OUT_BW) begin
         w = '0;
         for (int b = 0; b < OUT_BW; b++) w.data[b] = bits_q.pop_front();
         exp_q.push_back(w);
      end
   endtask

   task automatic model_flush();
      word_t w;
      if (bits_q.size() > 0) begin
         w = '0;
         w.last = 1'b1;
         for (int b = 0; b < OUT_BW && bits_q.size() > 0; b++) w.data[b] = bits_q.pop_front();
         exp_q.push_back(w);
      end
   endtask

   // Compare process: every popped word against the model, and hold while stalled
   always @(negedge clk) begin
      word_t w;
      if (reset) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("hold_valid", out_valid, 1'b1);
            check("hold_data", out_data, prev_data);
            check("hold_last", out_last, prev_last);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_word: got 0x%08h, expected no word", out_data);
            end else begin
               w = exp_q.pop_front();
               check("word_data", out_data, w.data);
               check("word_last", out_last, w.last);
            end
            w.data = out_data;
            w.last = out_last;
            got_q.push_back(w);
         end
         if (flush_done) fd_count++;
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         prev_last  = out_last;
      end
   end

   task automatic send_vec(input logic [BW*COL-1:0] v);
      int n = 0;
      bit ok = 1'b0;
      in_data  = v;
      in_valid = 1'b1;
      while (n < 300) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
         n++;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (ok) model_push(v);
      else fail_now("send_vec_timeout");
   endtask

   task automatic start_flush();
      flush = 1'b1;
      model_flush();
      @(posedge clk);
      #1;
      flush = 1'b0;
   endtask

   task automatic wait_flush_done(input int start, output int lat);
      lat = 0;
      while (fd_count == start && lat < 400) begin
         @(posedge clk);
         lat++;
      end
      if (fd_count == start) fail_now("flush_done_timeout");
      repeat (3) @(posedge clk);
      #1;
      check("flush_done_once", 64'(fd_count - start), 64'd1);
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 400) begin
         @(posedge clk);
         n++;
      end
      if (n >= 400) fail_now("drain_timeout");
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic check_got(input string name, input int i, input logic [OUT_BW-1:0] d, input logic l);
      if (i >= got_q.size()) begin
         fail_now(name);
      end else begin
         check(name, got_q[i].data, d);
         check(name, got_q[i].last, l);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base;
      int fds;
      int lat;
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      flush     = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_in_ready", in_ready, 1'b1);
      check("reset_out_valid", out_valid, 1'b0);
      check("reset_out_data", out_data, '0);
      check("reset_out_last", out_last, 1'b0);
      check("reset_flush_done", flush_done, 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Four all-zero vectors fill exactly one word
      base = got_q.size();
      for (int k = 0; k < 4; k++) send_vec('0);
      wait_drain();
      check("zeros_word_count", 64'(got_q.size() - base), 64'd1);
      check_got("zeros_word", base, 32'h0000_0000, 1'b0);

      // Flush in IDLE with an empty buffer: no word, prompt flush_done
      base = got_q.size();
      fds  = fd_count;
      start_flush();
      wait_flush_done(fds, lat);
      check("idle_flush_latency_ok", 64'(lat <= 2), 64'd1);
      check("idle_flush_no_word", 64'(got_q.size() - base), 64'd0);

      // Eight 0x7 elements then flush
      base = got_q.size();
      fds  = fd_count;
      send_vec(32'h7777_7777);
      start_flush();
      wait_flush_done(fds, lat);
      wait_drain();
      check_got("sevens_word0", base, 32'hDEF7_BDEF, 1'b0);
      check_got("sevens_word1", base + 1, 32'h0000_007B, 1'b1);

      // Same with the consumer stalled for 20 cycles
      base = got_q.size();
      fds  = fd_count;
      out_ready = 1'b0;
      send_vec(32'h7777_7777);
      start_flush();
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         check("stall_in_ready", in_ready, 1'b0);
      end
      check("stall_out_valid", out_valid, 1'b1);
      check("stall_out_data", out_data, 32'hDEF7_BDEF);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      wait_flush_done(fds, lat);
      wait_drain();
      check_got("stall_word0", base, 32'hDEF7_BDEF, 1'b0);
      check_got("stall_word1", base + 1, 32'h0000_007B, 1'b1);

      // Reset in the middle of encoding discards everything
      send_vec(32'h1234_5678);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      bits_q.delete();
      exp_q.delete();
      @(negedge clk);
      check("post_reset_in_ready", in_ready, 1'b1);
      check("post_reset_out_valid", out_valid, 1'b0);
      base = got_q.size();
      fds  = fd_count;
      send_vec('0);
      start_flush();
      wait_flush_done(fds, lat);
      wait_drain();
      check("post_reset_word_count", 64'(got_q.size() - base), 64'd1);
      check_got("post_reset_word", base, 32'h0000_0000, 1'b1);

      // Mixed vector {0,0,5,0,-3,0,0,2}, from a fresh reset for the counters
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      base = got_q.size();
      fds  = fd_count;
      send_vec(32'h200D_0500);
      start_flush();
      wait_flush_done(fds, lat);
      wait_drain();
      check_got("mixed_word", base, 32'h0002_9B2C, 1'b1);
`ifdef HUFF_STATS_EN
      check("stats_zero_cnt", zero_cnt, 32'd5);
      check("stats_word_cnt", word_cnt, 32'd1);
`endif

      check("leftover_expected_words", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
